// File: rtl/mmm_redc_seq.sv
// Word-serial Montgomery reduction: o_res = i_t * 2^-DW mod i_n, one WW-bit word per cycle.
// Define MMM_REDC_CNT_EN to add the o_cnt completed-result counter port.
module mmm_redc_seq #(
    parameter int DW = 256,
    parameter int WW = 64,
    parameter int PW = 2*DW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_vld,
    output logic          o_rdy,
    input  logic [PW-1:0] i_t,
    input  logic [DW-1:0] i_n,
    input  logic [WW-1:0] i_n0inv,
    output logic          o_vld,
    input  logic          i_rdy,
    output logic [DW-1:0] o_res
`ifdef MMM_REDC_CNT_EN
    ,
    output logic [31:0]   o_cnt
`endif
);

    localparam int NW = DW / WW;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NW - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RED  = 2'd1,
        S_SUB  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nx;
    logic [CW-1:0]    cnt_r;
    logic [PW:0]      acc_r;
    logic [DW-1:0]    n_r;
    logic [WW-1:0]    n0inv_r;
    logic [DW-1:0]    o_res_r;
    logic             o_vld_r;
    logic             o_rdy_r;

    logic [WW-1:0]    m_s;
    logic [WW+DW-1:0] mn_s;
    logic [PW:0]      sum_s;
    logic             ge_s;
    logic [DW-1:0]    diff_s;
    logic             accept_s;

    assign accept_s = i_vld && o_rdy_r;

    // Low word of acc + m*N is zero, so the shift drops nothing.
    assign m_s    = acc_r[WW-1:0] * n0inv_r;
    assign mn_s   = {{DW{1'b0}}, m_s} * {{WW{1'b0}}, n_r};
    assign sum_s  = acc_r + {{(PW + 1 - WW - DW){1'b0}}, mn_s};
    // Reduced value is below 2N, so DW+1 bits decide the final subtract.
    assign ge_s   = (acc_r[DW:0] >= {1'b0, n_r});
    assign diff_s = acc_r[DW-1:0] - n_r;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) state_nx = S_RED;
                else          state_nx = S_IDLE;
            end
            S_RED: begin
                if (cnt_r == CNT_LAST) state_nx = S_SUB;
                else                   state_nx = S_RED;
            end
            S_SUB: state_nx = S_OUT;
            S_OUT: begin
                if (i_rdy) state_nx = S_IDLE;
                else       state_nx = S_OUT;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r   <= {CW{1'b0}};
            acc_r   <= {(PW + 1){1'b0}};
            n_r     <= {DW{1'b0}};
            n0inv_r <= {WW{1'b0}};
            o_res_r <= {DW{1'b0}};
            o_vld_r <= 1'b0;
            o_rdy_r <= 1'b1;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        acc_r   <= {1'b0, i_t};
                        n_r     <= i_n;
                        n0inv_r <= i_n0inv;
                        cnt_r   <= {CW{1'b0}};
                    end
                end
                S_RED: begin
                    acc_r <= sum_s >> WW;
                    cnt_r <= cnt_r + CNT_ONE;
                end
                S_SUB: begin
                    o_res_r <= ge_s ? diff_s : acc_r[DW-1:0];
                end
                default: begin
                end
            endcase
            o_vld_r <= (state_nx == S_OUT);
            // Ready stays low for one cycle after the output handshake.
            o_rdy_r <= (state_nx == S_IDLE) && (state_r != S_OUT);
        end
    end

    assign o_vld = o_vld_r;
    assign o_rdy = o_rdy_r;
    assign o_res = o_res_r;

`ifdef MMM_REDC_CNT_EN
    logic [31:0] cnt_done_r;

    // Completed-result counter, wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_done_r <= 32'd0;
        end else if (o_vld_r && i_rdy) begin
            cnt_done_r <= cnt_done_r + 32'd1;
        end else begin
            cnt_done_r <= cnt_done_r;
        end
    end

    assign o_cnt = cnt_done_r;
`endif

endmodule

// File: tb/tb_mmm_redc_seq.sv
// Self-checking bench for mmm_redc_seq: scoreboard of expected reductions, random stalls.
// Checks o_cnt as well when MMM_REDC_CNT_EN is defined.
module tb_mmm_redc_seq;

    logic         clk;
    logic         rstn;
    logic         i_vld;
    logic         o_rdy;
    logic [511:0] i_t;
    logic [255:0] i_n;
    logic [63:0]  i_n0inv;
    logic         o_vld;
    logic         i_rdy;
    logic [255:0] o_res;
`ifdef MMM_REDC_CNT_EN
    logic [31:0]  o_cnt;
`endif

    mmm_redc_seq dut (
        .clk     (clk),
        .rstn    (rstn),
        .i_vld   (i_vld),
        .o_rdy   (o_rdy),
        .i_t     (i_t),
        .i_n     (i_n),
        .i_n0inv (i_n0inv),
        .o_vld   (o_vld),
        .i_rdy   (i_rdy),
        .o_res   (o_res)
`ifdef MMM_REDC_CNT_EN
        ,
        .o_cnt   (o_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_vec;
    int           n_err;
    int           done_cnt;
    bit           rand_rdy;
    logic [255:0] n_c;
    logic [255:0] exp_q[$];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: reduce mod N, then halve mod N DW times (bit-serial R^-1).
    function automatic logic [255:0] model(input logic [511:0] t);
        logic [511:0] r;
        logic [256:0] x;
        r = t % {256'd0, n_c};
        x = {1'b0, r[255:0]};
        for (int i = 0; i < 256; i++) begin
            if (x[0]) x = (x + {1'b0, n_c}) >> 1;
            else      x = x >> 1;
        end
        return x[255:0];
    endfunction

    function automatic logic [63:0] calc_n0inv(input logic [63:0] n0);
        logic [63:0] x;
        x = n0;
        for (int i = 0; i < 6; i++) x = x * (64'd2 - n0 * x);
        return 64'd0 - x;
    endfunction

    function automatic logic [255:0] rnd_mod();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v % n_c;
    endfunction

    // One clock: account for the handshakes this edge will perform, then advance.
    task automatic tick();
        if (rand_rdy) i_rdy = ($urandom_range(0, 3) != 0);
        if (o_vld && i_rdy) begin
            done_cnt++;
            if (exp_q.size() == 0) chk("unexpected_result", o_res, 256'd0 - 256'd1);
            else                   chk("res", o_res, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [511:0] t, input logic [255:0] exp);
        int b;
        bit ok;
        ok = 1'b0;
        i_t   = t;
        i_vld = 1'b1;
        b = 0;
        while (!ok && b < 200) begin
            if (o_rdy) begin
                exp_q.push_back(exp);
                ok = 1'b1;
            end
            tick();
            b++;
        end
        i_vld = 1'b0;
        if (!ok) chk("accept_timeout", 256'd0, 256'd1);
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (exp_q.size() > 0 && b < 400) begin
            tick();
            b++;
        end
        if (exp_q.size() > 0) begin
            chk("drain_timeout", 256'(exp_q.size()), 256'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        logic [511:0] t;
        logic [511:0] r_sh;
        logic [255:0] a;
        logic [255:0] b;
        int           lat;

        n_vec    = 0;
        n_err    = 0;
        done_cnt = 0;
        rand_rdy = 1'b0;
        n_c      = {1'b0, {255{1'b1}}} - 256'd18;
        i_n      = n_c;
        i_n0inv  = calc_n0inv(n_c[63:0]);
        r_sh     = 512'd1 << 256;
        rstn     = 1'b0;
        i_vld    = 1'b0;
        i_rdy    = 1'b1;
        i_t      = 512'd0;

        #23;
        chk("rst_vld", {255'd0, o_vld}, 256'd0);
        chk("rst_rdy", {255'd0, o_rdy}, 256'd1);
        chk("rst_res", o_res, 256'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Zero product and accept-to-valid latency.
        send(512'd0, 256'd0);
        lat = 0;
        while (!o_vld && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency", 256'(lat), 256'd5);
        drain();

        // Known reductions.
        send(r_sh, 256'd1);
        send(r_sh * 512'd5, 256'd5);
        send({256'd0, n_c}, 256'd0);
        t = {256'd0, n_c - 256'd1} * {256'd0, n_c - 256'd1};
        send(t, model(t));
        drain();

        // Backpressure with an extra product offered during the stall.
        i_rdy = 1'b0;
        a = rnd_mod();
        b = rnd_mod();
        t = {256'd0, a} * {256'd0, b};
        send(t, model(t));
        lat = 0;
        while (!o_vld && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp_vld_rise", {255'd0, o_vld}, 256'd1);
        i_vld = 1'b1;
        i_t   = r_sh;
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() > 0) chk("bp_res", o_res, exp_q[0]);
            chk("bp_rdy", {255'd0, o_rdy}, 256'd0);
            chk("bp_vld", {255'd0, o_vld}, 256'd1);
            tick();
        end
        i_vld = 1'b0;
        i_rdy = 1'b1;
        tick();
        chk("post_hs_vld", {255'd0, o_vld}, 256'd0);
        chk("post_hs_rdy", {255'd0, o_rdy}, 256'd0);
        chk("post_hs_q", 256'(exp_q.size()), 256'd0);
        tick();
        chk("idle_rdy", {255'd0, o_rdy}, 256'd1);
        chk("idle_vld", {255'd0, o_vld}, 256'd0);

        // Reset during the second reduction cycle aborts the job.
        send(r_sh * 512'd7, 256'd7);
        tick();
        rstn = 1'b0;
        #3;
        chk("abort_vld", {255'd0, o_vld}, 256'd0);
        chk("abort_rdy", {255'd0, o_rdy}, 256'd1);
        rstn = 1'b1;
        exp_q.delete();
        done_cnt = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) tick();
        chk("abort_no_out", {255'd0, o_vld}, 256'd0);
        chk("abort_idle_rdy", {255'd0, o_rdy}, 256'd1);
        a = rnd_mod();
        b = rnd_mod();
        t = {256'd0, a} * {256'd0, b};
        send(t, model(t));
        drain();

        // Random products with random downstream stalls.
        rand_rdy = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            a = rnd_mod();
            b = rnd_mod();
            t = {256'd0, a} * {256'd0, b};
            send(t, model(t));
            if ($urandom_range(0, 3) == 0) tick();
        end
        drain();
        rand_rdy = 1'b0;
        i_rdy    = 1'b1;

`ifdef MMM_REDC_CNT_EN
        chk("o_cnt", {224'd0, o_cnt}, 256'(done_cnt));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
